// File: rtl/imm_gen_pkg.sv
// Shared format codes, opcode constants and compressed funct3 values for the
// immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_SB    = 3'd3,
    FMT_U     = 3'd4,
    FMT_UJ    = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ILL   = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  // Compressed encodings keyed as {funct3, quadrant}
  localparam logic [4:0] C_ADDI = 5'b000_01;
  localparam logic [4:0] C_LI   = 5'b010_01;
  localparam logic [4:0] C_J    = 5'b101_01;
  localparam logic [4:0] C_BEQZ = 5'b110_01;
  localparam logic [4:0] C_BNEZ = 5'b111_01;
  localparam logic [4:0] C_LW   = 5'b010_00;
  localparam logic [4:0] C_SW   = 5'b110_00;

  function automatic logic is_shift_imm(input logic [6:0] opc, input logic [2:0] f3);
    return (opc == OPC_OP_IMM || opc == OPC_OP_IMM_32) && (f3 == F3_SLL || f3 == F3_SRX);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Format decode and immediate assembly for one instruction word (IMM_GEN_RVC_EN adds compressed decode).
// Purely combinational: zero latency, no handshake or backpressure.
// Sign extension relies on size casts of signed concatenations.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt
);

  logic [2:0] f3;
  assign f3 = instr[14:12];

  always_comb begin
    fmt = FMT_ILL;
    imm = '0;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OPC_OP, OPC_OP_32: fmt = FMT_R;
        OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
          if (is_shift_imm(instr[6:0], f3)) begin
            fmt = FMT_SHAMT;
            imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
          end else begin
            fmt = FMT_I;
            imm = XLEN'($signed(instr[31:20]));
          end
        end
        OPC_STORE: begin
          fmt = FMT_S;
          imm = XLEN'($signed({instr[31:25], instr[11:7]}));
        end
        OPC_BRANCH: begin
          fmt = FMT_SB;
          imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          imm = XLEN'($signed({instr[31:12], 12'b0}));
        end
        OPC_JAL: begin
          fmt = FMT_UJ;
          imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        end
        default: ;
      endcase
    end else begin
`ifdef IMM_GEN_RVC_EN
      case ({instr[15:13], instr[1:0]})
        C_ADDI, C_LI: begin
          fmt = FMT_I;
          imm = XLEN'($signed({instr[12], instr[6:2]}));
        end
        C_J: begin
          fmt = FMT_UJ;
          imm = XLEN'($signed({instr[12], instr[8], instr[10:9], instr[6], instr[7],
                               instr[2], instr[11], instr[5:3], 1'b0}));
        end
        C_BEQZ, C_BNEZ: begin
          fmt = FMT_SB;
          imm = XLEN'($signed({instr[12], instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0}));
        end
        C_LW: begin
          fmt = FMT_I;
          imm = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
        end
        C_SW: begin
          fmt = FMT_S;
          imm = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
        end
        default: ;
      endcase
`endif
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a QDEPTH-entry result queue; IMM_GEN_RVC_EN enables compressed decode.
// Latency: a pushed result is at the head one cycle later.
// Backpressure: in_ready only from registered count, so a full queue stalls even on a pop.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
  } entry_t;

  entry_t        q [QDEPTH];
  entry_t        dec_entry;
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (in_instr),
    .imm   (dec_entry.imm),
    .fmt   (dec_entry.fmt)
  );

  assign in_ready  = (count < CW'(QDEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage is left unreset; out_valid gates everything visible downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        q[wr_ptr] <= dec_entry;
        wr_ptr    <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head        = q[rd_ptr];
  assign out_imm     = out_valid ? head.imm : '0;
  assign out_fmt     = out_valid ? head.fmt : 3'd0;
  assign out_illegal = out_valid && (head.fmt == FMT_ILL);

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives identical traffic into 32- and 64-bit instances and checks both against a queue model.
module tb_imm_gen_pipe;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .QDEPTH(QD)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_illegal(out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64), .QDEPTH(QD)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  typedef struct {
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
  } exp_t;

  exp_t mq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic logic [63:0] fit32(input longint v);
    logic [63:0] r;
    r = v;
    r[63:32] = '0;
    return r;
  endfunction

  // Reference: field values reassembled as integers from the ISA bit placements
  function automatic exp_t model(input logic [31:0] ins);
    exp_t        e;
    longint      v;
    logic [2:0]  f;
    bit          sh;
    logic [6:0]  opc;
    logic [2:0]  f3;
    v   = 0;
    f   = 3'd7;
    sh  = 0;
    opc = ins[6:0];
    f3  = ins[14:12];
    if (ins[1:0] == 2'b11) begin
      if (opc inside {7'h33, 7'h3B}) f = 3'd0;
      else if (opc inside {7'h13, 7'h1B} && f3 inside {3'b001, 3'b101}) begin
        f = 3'd6; sh = 1;
      end else if (opc inside {7'h13, 7'h03, 7'h67, 7'h1B, 7'h73}) begin
        f = 3'd1; v = sx(longint'(ins[31:20]), 12);
      end else if (opc == 7'h23) begin
        f = 3'd2; v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      end else if (opc == 7'h63) begin
        f = 3'd3;
        v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
               longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
      end else if (opc inside {7'h37, 7'h17}) begin
        f = 3'd4; v = sx(longint'(ins[31:12]) * 4096, 32);
      end else if (opc == 7'h6F) begin
        f = 3'd5;
        v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 +
               longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      end
    end else begin
`ifdef IMM_GEN_RVC_EN
      if (ins[1:0] == 2'b01 && ins[15:13] inside {3'b000, 3'b010}) begin
        f = 3'd1; v = sx(longint'(ins[12]) * 32 + longint'(ins[6:2]), 6);
      end else if (ins[1:0] == 2'b01 && ins[15:13] == 3'b101) begin
        f = 3'd5;
        v = sx(longint'(ins[12]) * 2048 + longint'(ins[8]) * 1024 + longint'(ins[10:9]) * 256 +
               longint'(ins[6]) * 128 + longint'(ins[7]) * 64 + longint'(ins[2]) * 32 +
               longint'(ins[11]) * 16 + longint'(ins[5:3]) * 2, 12);
      end else if (ins[1:0] == 2'b01 && ins[15:13] inside {3'b110, 3'b111}) begin
        f = 3'd3;
        v = sx(longint'(ins[12]) * 256 + longint'(ins[6:5]) * 64 + longint'(ins[2]) * 32 +
               longint'(ins[11:10]) * 8 + longint'(ins[4:3]) * 2, 9);
      end else if (ins[1:0] == 2'b00 && ins[15:13] inside {3'b010, 3'b110}) begin
        f = (ins[15:13] == 3'b010) ? 3'd1 : 3'd2;
        v = longint'(ins[5]) * 64 + longint'(ins[12:10]) * 8 + longint'(ins[6]) * 4;
      end
`endif
    end
    e.fmt = f;
    if (sh) begin
      e.imm32 = 64'(ins[24:20]);
      e.imm64 = 64'(ins[25:20]);
    end else begin
      e.imm32 = fit32(v);
      e.imm64 = v;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 6) begin
      case ($urandom_range(0, 12))
        0:  r[6:0] = 7'h33;  1: r[6:0] = 7'h3B;  2: r[6:0] = 7'h13;
        3:  r[6:0] = 7'h03;  4: r[6:0] = 7'h67;  5: r[6:0] = 7'h1B;
        6:  r[6:0] = 7'h73;  7: r[6:0] = 7'h23;  8: r[6:0] = 7'h63;
        9:  r[6:0] = 7'h37; 10: r[6:0] = 7'h17; 11: r[6:0] = 7'h6F;
        default: r[6:0] = 7'h7F;
      endcase
    end else if (k < 8) begin
      r[1:0] = 2'($urandom_range(0, 2));
    end
    return r;
  endfunction

  task automatic check_all();
    exp_t h;
    bit   ev;
    ev = (mq.size() > 0);
    if (ev) h = mq[0];
    else h = '{64'd0, 64'd0, 3'd0};
    chk("valid32", 64'(out_valid32), 64'(ev));
    chk("ready32", 64'(in_ready32), 64'(mq.size() < QD));
    chk("fmt32", 64'(out_fmt32), 64'(h.fmt));
    chk("ill32", 64'(out_illegal32), 64'(h.fmt == 3'd7));
    chk("imm32", 64'(out_imm32), h.imm32);
    chk("valid64", 64'(out_valid64), 64'(ev));
    chk("ready64", 64'(in_ready64), 64'(mq.size() < QD));
    chk("fmt64", 64'(out_fmt64), 64'(h.fmt));
    chk("ill64", 64'(out_illegal64), 64'(h.fmt == 3'd7));
    chk("imm64", out_imm64, h.imm64);
  endtask

  task automatic cycle(input bit v, input logic [31:0] ins, input bit rdy, input bit r);
    bit do_pop;
    bit do_push;
    rst       = r;
    in_valid  = v;
    in_instr  = ins;
    out_ready = rdy;
    @(posedge clk);
    do_pop  = (mq.size() > 0) && rdy;
    do_push = v && (mq.size() < QD);
    if (r) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(model(ins));
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    @(negedge clk);
    cycle(1, 32'h0010_0093, 0, 1);
    chk("rst_valid", 64'(out_valid32), 64'd0);
    chk("rst_ready", 64'(in_ready32), 64'd1);

    cycle(1, 32'hFFF0_0093, 1, 0);
    chk("addi_fmt", 64'(out_fmt32), 64'd1);
    chk("addi_imm32", 64'(out_imm32), 64'hFFFF_FFFF);
    cycle(1, 32'h8000_006F, 1, 0);
    chk("jal_fmt", 64'(out_fmt64), 64'd5);
    chk("jal_imm64", out_imm64, 64'hFFFF_FFFF_FFF0_0000);
    cycle(1, 32'h43F0_5093, 1, 0);
    chk("srai_fmt", 64'(out_fmt64), 64'd6);
    chk("srai_imm64", out_imm64, 64'h3F);
    cycle(1, 32'h0000_007F, 1, 0);
    chk("ill_flag", 64'(out_illegal32), 64'd1);
    chk("ill_imm", 64'(out_imm32), 64'd0);
    cycle(1, 32'h0000_0505, 1, 0);
`ifdef IMM_GEN_RVC_EN
    chk("caddi_fmt", 64'(out_fmt32), 64'd1);
    chk("caddi_imm", 64'(out_imm32), 64'd1);
`else
    chk("caddi_fmt", 64'(out_fmt32), 64'd7);
`endif
    cycle(0, 32'h0, 1, 0);

    // Fill with consumer stalled, then see the third push wait for a pop
    cycle(1, 32'h0010_0093, 0, 0);
    cycle(1, 32'h0020_0093, 0, 0);
    chk("full_ready", 64'(in_ready32), 64'd0);
    cycle(1, 32'h0030_0093, 0, 0);
    chk("head_hold", 64'(out_imm32), 64'd1);
    cycle(1, 32'h0030_0093, 1, 0);
    chk("pop_no_push", 64'(out_imm32), 64'd2);
    cycle(1, 32'h0030_0093, 0, 0);
    cycle(0, 32'h0, 1, 0);
    chk("order_c", 64'(out_imm32), 64'd3);
    cycle(0, 32'h0, 1, 0);

    // Reset with two entries queued, then a lone push
    cycle(1, 32'h0010_0093, 0, 0);
    cycle(1, 32'h0020_0093, 0, 0);
    cycle(1, 32'h0030_0093, 0, 1);
    chk("midrst_valid", 64'(out_valid32), 64'd0);
    cycle(1, 32'h0040_0093, 1, 0);
    chk("after_rst_imm", 64'(out_imm32), 64'd4);
    cycle(0, 32'h0, 1, 0);
    chk("after_rst_empty", 64'(out_valid32), 64'd0);

    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
